logic_macro_array: RTL and testbench

- Parametrised successor of the PP3 logic macro: NUM_CELLS logic cells, each a top/bottom N:1 mux fragment pair with configurable input inverters and a cell output register.
- New relative to the single macro:
  - generic mux depth;
  - per-cell register mode (D or toggle);
  - a cell-to-cell shift chain;
  - synchronous set/clear alongside a single asynchronous active-low reset.
- Used as a CLB-level primitive for packing wide muxes, counters and shift registers.

---
 rtl/pp3_logic_pkg.sv | 17 +
 rtl/logic_macro_cell.sv | 68 ++++++
 rtl/logic_macro_array.sv | 78 +++++++
 tb/tb_logic_macro_array.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pp3_logic_pkg.sv
// rtl/pp3_logic_pkg.sv - shared constants and helpers for the logic macro array
package pp3_logic_pkg;

    localparam int QMODE_D = 0;
    localparam int QMODE_T = 1;

    // Register update priority at a rising edge, lowest value wins
    localparam int PRIO_SET   = 0;
    localparam int PRIO_CLEAR = 1;
    localparam int PRIO_EN    = 2;
    localparam int PRIO_HOLD  = 3;

    function automatic int mux_inputs(input int sel_w);
        return 1 << sel_w;
    endfunction

endpackage

// File: rtl/logic_macro_cell.sv
// rtl/logic_macro_cell.sv - one logic cell: inverting top/bottom mux pair and output register
module logic_macro_cell
    import pp3_logic_pkg::*;
#(
    parameter int                      SEL_W   = 2,
    parameter logic [(1<<SEL_W)-1:0]   T_INV   = '0,
    parameter logic [(1<<SEL_W)-1:0]   B_INV   = '0,
    parameter bit                      QZ_INIT = 1'b0,
    parameter bit                      Q_MODE  = 1'b0
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_run,
    input  logic [(1<<SEL_W)-1:0]   i_td,
    input  logic [SEL_W-1:0]        i_tsel,
    input  logic [(1<<SEL_W)-1:0]   i_bd,
    input  logic [SEL_W-1:0]        i_bsel,
    input  logic                    i_tbs,
    input  logic                    i_shift_in,
    input  logic                    i_qds,
    input  logic                    i_qen,
    input  logic                    i_qst,
    input  logic                    i_qrt,
    output logic                    o_tz,
    output logic                    o_cz,
    output logic                    o_qz
);

    localparam int N      = mux_inputs(SEL_W);
    localparam bit TOGGLE = (Q_MODE == 1'(QMODE_T));

    logic [N-1:0] w_td;
    logic [N-1:0] w_bd;
    logic         w_tz;
    logic         w_bz;
    logic         w_cz;
    logic         w_d;
    logic         w_next;
    logic         r_qz;

    assign w_td   = i_td ^ T_INV;
    assign w_bd   = i_bd ^ B_INV;
    assign w_tz   = w_td[i_tsel];
    assign w_bz   = w_bd[i_bsel];
    assign w_cz   = i_tbs ? w_bz : w_tz;
    assign w_d    = i_qds ? i_shift_in : w_cz;
    assign w_next = TOGGLE ? (r_qz ^ w_d) : w_d;

    // i_run is low on the edge that samples reset release, so that edge never updates
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_qz <= QZ_INIT;
        end else if (i_run) begin
            if (i_qst) begin
                r_qz <= 1'b1;
            end else if (i_qrt) begin
                r_qz <= 1'b0;
            end else if (i_qen) begin
                r_qz <= w_next;
            end
        end
    end

    assign o_tz = w_tz;
    assign o_cz = w_cz;
    assign o_qz = r_qz;

endmodule

// File: rtl/logic_macro_array.sv
// rtl/logic_macro_array.sv - array of logic macro cells with optional register shift chain
module logic_macro_array
    import pp3_logic_pkg::*;
#(
    parameter int                                NUM_CELLS = 4,
    parameter int                                SEL_W     = 2,
    parameter logic [(NUM_CELLS<<SEL_W)-1:0]     T_INV     = '0,
    parameter logic [(NUM_CELLS<<SEL_W)-1:0]     B_INV     = '0,
    parameter logic [NUM_CELLS-1:0]              QZ_INIT   = '0,
    parameter logic [NUM_CELLS-1:0]              Q_TOGGLE  = '0,
    parameter bit                                CHAIN_EN  = 1'b0
) (
    input  logic                                 QCK,
    input  logic                                 QRN,
    input  logic [(NUM_CELLS<<SEL_W)-1:0]        TD,
    input  logic [NUM_CELLS*SEL_W-1:0]           TSEL,
    input  logic [(NUM_CELLS<<SEL_W)-1:0]        BD,
    input  logic [NUM_CELLS*SEL_W-1:0]           BSEL,
    input  logic [NUM_CELLS-1:0]                 TBS,
    input  logic [NUM_CELLS-1:0]                 QDI,
    input  logic [NUM_CELLS-1:0]                 QDS,
    input  logic [NUM_CELLS-1:0]                 QEN,
    input  logic                                 QST,
    input  logic                                 QRT,
    output logic [NUM_CELLS-1:0]                 TZ,
    output logic [NUM_CELLS-1:0]                 CZ,
    output logic [NUM_CELLS-1:0]                 QZ
);

    localparam int N = mux_inputs(SEL_W);

    logic r_run;

    // Goes high one edge after reset release; gates every cell register
    always_ff @(posedge QCK or negedge QRN) begin
        if (!QRN) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_CELLS; i++) begin : g_cell
        logic w_shift_in;

        if (CHAIN_EN && i > 0) begin : g_chain
            assign w_shift_in = QZ[i-1];
        end else begin : g_direct
            assign w_shift_in = QDI[i];
        end

        logic_macro_cell #(
            .SEL_W   (SEL_W),
            .T_INV   (T_INV[i*N +: N]),
            .B_INV   (B_INV[i*N +: N]),
            .QZ_INIT (QZ_INIT[i]),
            .Q_MODE  (Q_TOGGLE[i])
        ) u_cell (
            .i_clk      (QCK),
            .i_rst_n    (QRN),
            .i_run      (r_run),
            .i_td       (TD[i*N +: N]),
            .i_tsel     (TSEL[i*SEL_W +: SEL_W]),
            .i_bd       (BD[i*N +: N]),
            .i_bsel     (BSEL[i*SEL_W +: SEL_W]),
            .i_tbs      (TBS[i]),
            .i_shift_in (w_shift_in),
            .i_qds      (QDS[i]),
            .i_qen      (QEN[i]),
            .i_qst      (QST),
            .i_qrt      (QRT),
            .o_tz       (TZ[i]),
            .o_cz       (CZ[i]),
            .o_qz       (QZ[i])
        );
    end

endmodule

// File: tb/tb_logic_macro_array.sv
// tb/tb_logic_macro_array.sv - self-checking bench for logic_macro_array
module tb_logic_macro_array;

    localparam logic [15:0] T_INV_A    = 16'h8241;
    localparam logic [15:0] B_INV_A    = 16'hA500;
    localparam logic [3:0]  QZ_INIT_A  = 4'b1010;
    localparam logic [3:0]  Q_TOGGLE_A = 4'b0000;
    localparam bit          CHAIN_EN_A = 1'b1;

    localparam logic [15:0] T_INV_B    = 16'h3C06;
    localparam logic [15:0] B_INV_B    = 16'h0F93;
    localparam logic [3:0]  QZ_INIT_B  = 4'b0101;
    localparam logic [3:0]  Q_TOGGLE_B = 4'b0010;
    localparam bit          CHAIN_EN_B = 1'b0;

    logic        QCK = 1'b0;
    logic        QRN;
    logic [15:0] TD, BD;
    logic [7:0]  TSEL, BSEL;
    logic [3:0]  TBS, QDI, QDS, QEN;
    logic        QST, QRT;
    logic [3:0]  tz_a, cz_a, qz_a, tz_b, cz_b, qz_b;

    int n_chk = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    bit [3:0] m_qa = '0;
    bit [3:0] m_qb = '0;
    bit       m_live = 1'b0;

    logic_macro_array #(
        .NUM_CELLS(4), .SEL_W(2), .T_INV(T_INV_A), .B_INV(B_INV_A),
        .QZ_INIT(QZ_INIT_A), .Q_TOGGLE(Q_TOGGLE_A), .CHAIN_EN(CHAIN_EN_A)
    ) dut_a (
        .QCK(QCK), .QRN(QRN), .TD(TD), .TSEL(TSEL), .BD(BD), .BSEL(BSEL),
        .TBS(TBS), .QDI(QDI), .QDS(QDS), .QEN(QEN), .QST(QST), .QRT(QRT),
        .TZ(tz_a), .CZ(cz_a), .QZ(qz_a)
    );

    logic_macro_array #(
        .NUM_CELLS(4), .SEL_W(2), .T_INV(T_INV_B), .B_INV(B_INV_B),
        .QZ_INIT(QZ_INIT_B), .Q_TOGGLE(Q_TOGGLE_B), .CHAIN_EN(CHAIN_EN_B)
    ) dut_b (
        .QCK(QCK), .QRN(QRN), .TD(TD), .TSEL(TSEL), .BD(BD), .BSEL(BSEL),
        .TBS(TBS), .QDI(QDI), .QDS(QDS), .QEN(QEN), .QST(QST), .QRT(QRT),
        .TZ(tz_b), .CZ(cz_b), .QZ(qz_b)
    );

    always #5 QCK = ~QCK;

    function automatic logic [3:0] f_mux(input logic [15:0] d, input logic [15:0] inv,
                                         input logic [7:0] sel);
        logic [15:0] v;
        logic [3:0]  r;
        v = d ^ inv;
        for (int c = 0; c < 4; c++) r[c] = v[c*4 + int'(sel[c*2 +: 2])];
        return r;
    endfunction

    function automatic logic [3:0] f_cz(input logic [15:0] tinv, input logic [15:0] binv);
        logic [3:0] t, b;
        t = f_mux(TD, tinv, TSEL);
        b = f_mux(BD, binv, BSEL);
        return (TBS & b) | (~TBS & t);
    endfunction

    function automatic bit [3:0] f_next(input bit [3:0] q, input logic [3:0] tog, input bit chain,
                                        input logic [3:0] cz);
        bit [3:0] r;
        bit       d;
        if (QST) return 4'b1111;
        if (QRT) return 4'b0000;
        r = q;
        for (int c = 0; c < 4; c++) begin
            if (!QDS[c])            d = cz[c];
            else if (chain && c > 0) d = q[c-1];
            else                    d = QDI[c];
            if (QEN[c]) r[c] = tog[c] ? (q[c] ^ d) : d;
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: reset restores init, first edge after release is dead
    always @(posedge QCK or negedge QRN) begin
        if (!QRN) begin
            m_qa   = QZ_INIT_A;
            m_qb   = QZ_INIT_B;
            m_live = 1'b0;
        end else if (!m_live) begin
            m_live = 1'b1;
        end else begin
            m_qa = f_next(m_qa, Q_TOGGLE_A, CHAIN_EN_A, f_cz(T_INV_A, B_INV_A));
            m_qb = f_next(m_qb, Q_TOGGLE_B, CHAIN_EN_B, f_cz(T_INV_B, B_INV_B));
        end
    end

    always @(negedge QCK) begin
        if (chk_on) begin
            chk("tz_a", tz_a, f_mux(TD, T_INV_A, TSEL));
            chk("cz_a", cz_a, f_cz(T_INV_A, B_INV_A));
            chk("qz_a", qz_a, m_qa);
            chk("tz_b", tz_b, f_mux(TD, T_INV_B, TSEL));
            chk("cz_b", cz_b, f_cz(T_INV_B, B_INV_B));
            chk("qz_b", qz_b, m_qb);
        end
    end

    task automatic step();
        @(posedge QCK);
        #1;
    endtask

    task automatic release_before_edge();
        @(negedge QCK);
        #4;
        QRN = 1'b1;
    endtask

    initial begin
        QRN = 1'b1;
        TD = '0; BD = '0; TSEL = '0; BSEL = '0;
        TBS = '0; QDI = '0; QDS = '0; QEN = '0; QST = 1'b0; QRT = 1'b0;

        // Async reset mid-cycle, no clock edge needed
        @(posedge QCK);
        #2;
        QRN = 1'b0;
        #1;
        chk("rst_imm_a", qz_a, 4'b1010);
        chk("rst_imm_b", qz_b, 4'b0101);
        chk_on = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rst_hold_a", qz_a, 4'b1010);
        end

        // Mux sweep on cell 0 of dut_a (top inverter mask 0001)
        TD = '0; TSEL = '0;
        #1 chk("tz0_sel0", {3'b0, tz_a[0]}, 4'b0001);
        TSEL = 8'h01;
        #1 chk("tz0_sel1", {3'b0, tz_a[0]}, 4'b0000);
        TBS = 4'b0001; BD = 16'h0004; BSEL = 8'h02;
        #1 chk("cz0_bot", {3'b0, cz_a[0]}, 4'b0001);

        // Release; first enabled edge after that shifts from init
        QEN = 4'b1111; QDS = 4'b1111; QDI = 4'b0000;
        release_before_edge();
        #2;
        chk("rel_edge_a", qz_a, 4'b1010);
        step();
        chk("shift_init_a", qz_a, 4'b0100);

        QRT = 1'b1;
        step();
        chk("clear_a", qz_a, 4'b0000);
        QRT = 1'b0;
        QDI = 4'b0001;
        step();
        chk("chain0", qz_a, 4'b0001);
        QDI = 4'b0000;
        step(); chk("chain1", qz_a, 4'b0010);
        step(); chk("chain2", qz_a, 4'b0100);
        step(); chk("chain3", qz_a, 4'b1000);
        step(); chk("chain4", qz_a, 4'b0000);

        // Set beats clear; clear alone next
        QST = 1'b1; QRT = 1'b1;
        step(); chk("prio_set", qz_a, 4'b1111);
        QST = 1'b0;
        step(); chk("prio_clr", qz_a, 4'b0000);
        QRT = 1'b0;

        // Reset 1 time unit after a loading edge, then release just before an edge
        QST = 1'b1;
        step(); chk("load_ones", qz_a, 4'b1111);
        QST = 1'b0;
        QRN = 1'b0;
        #1 chk("race_rst", qz_a, 4'b1010);
        QEN = 4'b1111; QDS = 4'b1111; QDI = 4'b0001;
        release_before_edge();
        #2 chk("race_ignored", qz_a, 4'b1010);
        step(); chk("race_load", qz_a, 4'b0101);

        // T flip-flop on dut_b cell 1 with constant-1 mux input
        QDI = '0; QDS = '0; QEN = 4'b0010; TBS = '0; TSEL = '0; BSEL = '0;
        TD = 16'h0010;
        step(); chk("tog1", {3'b0, qz_b[1]}, 4'b0001);
        step(); chk("tog2", {3'b0, qz_b[1]}, 4'b0000);
        step(); chk("tog3", {3'b0, qz_b[1]}, 4'b0001);
        step(); chk("tog4", {3'b0, qz_b[1]}, 4'b0000);
        QEN = '0;
        step(); chk("tog_hold1", {3'b0, qz_b[1]}, 4'b0000);
        step(); chk("tog_hold2", {3'b0, qz_b[1]}, 4'b0000);

        // Randomised traffic, including occasional reset pulses
        for (int k = 0; k < 400; k++) begin
            TD   = 16'($urandom);
            BD   = 16'($urandom);
            TSEL = 8'($urandom);
            BSEL = 8'($urandom);
            TBS  = 4'($urandom);
            QDI  = 4'($urandom);
            QDS  = 4'($urandom);
            QEN  = 4'($urandom);
            QST  = ($urandom_range(0, 15) == 0);
            QRT  = ($urandom_range(0, 11) == 0);
            QRN  = ($urandom_range(0, 24) != 0);
            step();
        end
        QRN = 1'b1;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
